// File: rtl/sum_latch_uart_frame_tx_if.sv
// rtl/sum_latch_uart_frame_tx_if.sv - operand/send/UART signal bundle for sum_latch_uart_frame_tx
interface sum_latch_uart_frame_tx_if #(
  parameter int W = 8
);
  logic         save_a_n;
  logic         save_b_n;
  logic [W-1:0] data_input;
  logic         mode;
  logic         send;
  logic [W:0]   result;
  logic         uart_txd;
  logic         uart_busy;

  // Board side: drives operands and requests, observes result and the TX pin
  modport master (
    output save_a_n, save_b_n, data_input, mode, send,
    input  result, uart_txd, uart_busy
  );

  // Block side
  modport slave (
    input  save_a_n, save_b_n, data_input, mode, send,
    output result, uart_txd, uart_busy
  );
endinterface

// File: rtl/sum_latch_uart_frame_tx.sv
// rtl/sum_latch_uart_frame_tx.sv - operand latch, add/sub result register and framed UART transmitter
module sum_latch_uart_frame_tx #(
  parameter int          W      = 8,
  parameter int          CLK_HZ = 50000000,
  parameter int          BAUD   = 115200,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input logic                    clk,
  input logic                    reset,
  sum_latch_uart_frame_tx_if.slave bus
);

  localparam int CPB = CLK_HZ / BAUD;
  // ceil((W+1)/8) result bytes after the header
  localparam int NB  = (W + 8) / 8;
  localparam int PW  = 8 * NB;
  localparam int FW  = PW + 8;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BYW = $clog2(NB + 1);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CPB - 1);
  localparam logic [BYW-1:0] BYTE_LAST = BYW'(NB);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W:0]     result_q, result_d;
  state_t         state_q, state_d;
  logic [CW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [BYW-1:0] byte_q, byte_d;
  logic [FW-1:0]  frame_q, frame_d;
  logic           busy_q, busy_d;
  logic           txd_q, txd_d;

  logic [PW-1:0]  padded;
  logic           fill;
  logic           baud_end;

  // Operand capture from the shared bus and the free-running add/sub result
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (!bus.save_a_n) a_d = bus.data_input;
    if (!bus.save_b_n) b_d = bus.data_input;
    if (bus.mode) result_d = {1'b0, a_q} - {1'b0, b_q};
    else          result_d = {1'b0, a_q} + {1'b0, b_q};
  end

  // Result widened to whole bytes: sign-extended for subtract, zero-filled for add
  always_comb begin
    fill         = bus.mode & result_q[W];
    padded       = {PW{fill}};
    padded[W:0]  = result_q;
  end

  // Serialiser next-state: header then result bytes, each as start/8 data/stop
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    frame_d  = frame_q;
    busy_d   = busy_q;
    baud_end = (baud_q == BAUD_LAST);

    case (state_q)
      IDLE: begin
        if (bus.send && !busy_q) begin
          state_d = START;
          frame_d = {padded, HEADER};
          busy_d  = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          baud_d  = '0;
        end else begin
          baud_d  = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          // After eight shifts the next byte of the frame sits in the low bits
          frame_d = frame_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d  = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q == BYTE_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            byte_d  = '0;
          end else begin
            byte_d  = byte_q + BYW'(1);
            state_d = START;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Line level follows the state being entered so the pin is registered
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = frame_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // Operand and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // Serialiser state; reset abandons any frame and idles the line high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      frame_q <= '0;
      busy_q  <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      txd_q   <= txd_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.uart_txd  = txd_q;
  assign bus.uart_busy = busy_q;

endmodule

// File: tb/tb_sum_latch_uart_frame_tx.sv
// tb/tb_sum_latch_uart_frame_tx.sv - self-checking bench for sum_latch_uart_frame_tx at W=8, 15 and 16
module tb_sum_latch_uart_frame_tx;

  typedef logic [63:0] u64;
  localparam int CPB = 10;
  localparam logic [7:0] HDR = 8'hA5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sum_latch_uart_frame_tx_if #(.W(8))  bus8 ();
  sum_latch_uart_frame_tx_if #(.W(15)) bus15 ();
  sum_latch_uart_frame_tx_if #(.W(16)) bus16 ();

  sum_latch_uart_frame_tx #(.W(8),  .CLK_HZ(1000), .BAUD(100), .HEADER(8'hA5))
    dut8  (.clk(clk), .reset(reset), .bus(bus8));
  sum_latch_uart_frame_tx #(.W(15), .CLK_HZ(1000), .BAUD(100), .HEADER(8'hA5))
    dut15 (.clk(clk), .reset(reset), .bus(bus15));
  sum_latch_uart_frame_tx #(.W(16), .CLK_HZ(1000), .BAUD(100), .HEADER(8'hA5))
    dut16 (.clk(clk), .reset(reset), .bus(bus16));

  int   errors = 0;
  int   checks = 0;
  u64   a_m [3];
  u64   b_m [3];
  logic mode_m;
  u64   exp_res [3];
  logic exp_mode;
  logic rxbit [3][64];
  int   rxn [3];
  int   got_len [3];
  int   len1 [3];
  int   gap [3];

  function automatic int w_of(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 15 : 16);
  endfunction

  function automatic int nb_of(input int k);
    return (w_of(k) + 8) / 8;
  endfunction

  function automatic u64 mask(input int bits);
    return (bits >= 64) ? '1 : ((u64'(1) << bits) - u64'(1));
  endfunction

  function automatic int exp_len(input int k);
    return (1 + nb_of(k)) * 10 * CPB;
  endfunction

  function automatic u64 model_result(input int k);
    u64 m;
    m = mask(w_of(k) + 1);
    return mode_m ? ((a_m[k] - b_m[k]) & m) : ((a_m[k] + b_m[k]) & m);
  endfunction

  function automatic logic [9:0] exp_sym(input int k, input int i);
    u64 v;
    u64 sh;
    logic [7:0] b;
    int w;
    w = w_of(k);
    v = exp_res[k];
    if (exp_mode && v[w]) v = v | (mask(8 * nb_of(k)) & ~mask(w + 1));
    sh = v >> (8 * (i - 1));
    b  = (i == 0) ? HDR : sh[7:0];
    return {1'b1, b, 1'b0};
  endfunction

  function automatic logic [9:0] got_sym(input int k, input int i);
    logic [9:0] s;
    for (int j = 0; j < 10; j++) s[j] = rxbit[k][i * 10 + j];
    return s;
  endfunction

  function automatic logic txd_of(input int k);
    case (k)
      0:       return bus8.uart_txd;
      1:       return bus15.uart_txd;
      default: return bus16.uart_txd;
    endcase
  endfunction

  function automatic logic busy_of(input int k);
    case (k)
      0:       return bus8.uart_busy;
      1:       return bus15.uart_busy;
      default: return bus16.uart_busy;
    endcase
  endfunction

  function automatic u64 result_of(input int k);
    case (k)
      0:       return u64'(bus8.result);
      1:       return u64'(bus15.result);
      default: return u64'(bus16.result);
    endcase
  endfunction

  task automatic drive(input logic sa, input logic sb, input logic [31:0] d, input logic md, input logic snd);
    bus8.save_a_n  = sa; bus15.save_a_n  = sa; bus16.save_a_n  = sa;
    bus8.save_b_n  = sb; bus15.save_b_n  = sb; bus16.save_b_n  = sb;
    bus8.data_input = d[7:0]; bus15.data_input = d[14:0]; bus16.data_input = d[15:0];
    bus8.mode = md; bus15.mode = md; bus16.mode = md;
    bus8.send = snd; bus15.send = snd; bus16.send = snd;
  endtask

  task automatic set_send(input int k, input logic v);
    case (k)
      0:       bus8.send = v;
      1:       bus15.send = v;
      default: bus16.send = v;
    endcase
  endtask

  // Load operand(s) and wait until the result register has caught up
  task automatic load(input logic sa_en, input logic sb_en, input logic [31:0] d, input logic md);
    @(negedge clk);
    drive(!sa_en, !sb_en, d, md, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (sa_en) a_m[k] = u64'(d) & mask(w_of(k));
      if (sb_en) b_m[k] = u64'(d) & mask(w_of(k));
    end
    mode_m = md;
    @(negedge clk);
    drive(1'b1, 1'b1, d, md, 1'b0);
    @(negedge clk);
  endtask

  // Pulse send; on return the first START clock of every frame is current
  task automatic send_start();
    @(negedge clk);
    for (int k = 0; k < 3; k++) exp_res[k] = model_result(k);
    exp_mode = mode_m;
    for (int k = 0; k < 3; k++) set_send(k, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 3; k++) set_send(k, 1'b0);
  endtask

  // Sample the line at mid-bit for as long as busy stays high
  task automatic capture(input int k);
    int c;
    int w;
    rxn[k] = 0;
    got_len[k] = 0;
    w = 0;
    while (busy_of(k) !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    c = 0;
    while (busy_of(k) === 1'b1 && c < 2000) begin
      if ((c % CPB) == CPB / 2 && rxn[k] < 64) begin
        rxbit[k][rxn[k]] = txd_of(k);
        rxn[k]++;
      end
      c++;
      @(negedge clk);
    end
    got_len[k] = c;
  endtask

  task automatic capture_all();
    fork
      capture(0);
      capture(1);
      capture(2);
    join
  endtask

  task automatic b2b(input int k);
    int g;
    capture(k);
    len1[k] = got_len[k];
    g = 0;
    while (busy_of(k) !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    gap[k] = g;
    set_send(k, 1'b0);
    capture(k);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin a_m[k] = 0; b_m[k] = 0; end
    mode_m = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (result_of(k) !== 0) begin errors++; $display("FAIL reset_result w=%0d: got %0h want 0", w_of(k), result_of(k)); end
      checks++;
      if (txd_of(k) !== 1'b1) begin errors++; $display("FAIL reset_txd w=%0d: got %b want 1", w_of(k), txd_of(k)); end
      checks++;
      if (busy_of(k) !== 1'b0) begin errors++; $display("FAIL reset_busy w=%0d: got %b want 0", w_of(k), busy_of(k)); end
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_add_carry();
    load(1'b1, 1'b0, 32'd200, 1'b0);
    load(1'b0, 1'b1, 32'd100, 1'b0);
    checks++;
    if (result_of(0) !== u64'(9'h12C)) begin errors++; $display("FAIL add_result_w8: got %0h want 12c", result_of(0)); end
    send_start();
    capture_all();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_len[k] !== exp_len(k)) begin errors++; $display("FAIL add_busy_len w=%0d: got %0d want %0d", w_of(k), got_len[k], exp_len(k)); end
      for (int i = 0; i <= nb_of(k); i++) begin
        checks++;
        if (got_sym(k, i) !== exp_sym(k, i)) begin errors++; $display("FAIL add_byte w=%0d i=%0d: got %h want %h", w_of(k), i, got_sym(k, i), exp_sym(k, i)); end
      end
    end
    checks++;
    if (got_sym(0, 1) !== {1'b1, 8'h2C, 1'b0} || got_sym(0, 2) !== {1'b1, 8'h01, 1'b0}) begin
      errors++; $display("FAIL add_frame_w8: got %h %h want 2c 01", got_sym(0, 1), got_sym(0, 2));
    end
  endtask

  task automatic test_sub_negative();
    load(1'b1, 1'b0, 32'd5, 1'b1);
    load(1'b0, 1'b1, 32'd7, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (result_of(k) !== model_result(k)) begin errors++; $display("FAIL sub_result w=%0d: got %0h want %0h", w_of(k), result_of(k), model_result(k)); end
    end
    checks++;
    if (result_of(0) !== u64'(9'h1FE)) begin errors++; $display("FAIL sub_result_w8: got %0h want 1fe", result_of(0)); end
    send_start();
    capture_all();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_len[k] !== exp_len(k)) begin errors++; $display("FAIL sub_busy_len w=%0d: got %0d want %0d", w_of(k), got_len[k], exp_len(k)); end
      for (int i = 0; i <= nb_of(k); i++) begin
        checks++;
        if (got_sym(k, i) !== exp_sym(k, i)) begin errors++; $display("FAIL sub_byte w=%0d i=%0d: got %h want %h", w_of(k), i, got_sym(k, i), exp_sym(k, i)); end
      end
    end
    checks++;
    if (got_sym(0, 2) !== {1'b1, 8'hFF, 1'b0}) begin errors++; $display("FAIL sub_sign_w8: got %h want ff", got_sym(0, 2)); end
  endtask

  task automatic test_simultaneous();
    load(1'b1, 1'b1, 32'hFF, 1'b0);
    checks++;
    if (result_of(0) !== u64'(9'h1FE)) begin errors++; $display("FAIL simul_result_w8: got %0h want 1fe", result_of(0)); end
    send_start();
    capture_all();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_len[k] !== exp_len(k)) begin errors++; $display("FAIL simul_busy_len w=%0d: got %0d want %0d", w_of(k), got_len[k], exp_len(k)); end
      for (int i = 0; i <= nb_of(k); i++) begin
        checks++;
        if (got_sym(k, i) !== exp_sym(k, i)) begin errors++; $display("FAIL simul_byte w=%0d i=%0d: got %h want %h", w_of(k), i, got_sym(k, i), exp_sym(k, i)); end
      end
    end
  endtask

  task automatic test_width();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        load(1'b1, 1'b0, 32'h7FFF, 1'b0);
        load(1'b0, 1'b1, 32'h1, 1'b0);
        checks++;
        if (result_of(1) !== u64'(16'h8000)) begin errors++; $display("FAIL width_result_w15: got %0h want 8000", result_of(1)); end
      end else begin
        load(1'b1, 1'b1, 32'hFFFF, 1'b0);
        checks++;
        if (result_of(2) !== u64'(17'h1FFFE)) begin errors++; $display("FAIL width_result_w16: got %0h want 1fffe", result_of(2)); end
      end
      send_start();
      capture_all();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_len[k] !== exp_len(k)) begin errors++; $display("FAIL width_busy_len w=%0d: got %0d want %0d", w_of(k), got_len[k], exp_len(k)); end
        for (int i = 0; i <= nb_of(k); i++) begin
          checks++;
          if (got_sym(k, i) !== exp_sym(k, i)) begin errors++; $display("FAIL width_byte w=%0d i=%0d: got %h want %h", w_of(k), i, got_sym(k, i), exp_sym(k, i)); end
        end
      end
    end
  endtask

  task automatic test_ignored_send();
    int seen;
    load(1'b1, 1'b0, 32'h3C, 1'b0);
    load(1'b0, 1'b1, 32'h11, 1'b0);
    send_start();
    fork
      capture_all();
      begin
        repeat (60) @(negedge clk);
        drive(1'b1, 1'b0, 32'h44, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) b_m[k] = 64'h44;
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h44, 1'b0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (result_of(k) !== model_result(k)) begin errors++; $display("FAIL midframe_result w=%0d: got %0h want %0h", w_of(k), result_of(k), model_result(k)); end
        end
      end
    join
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_len[k] !== exp_len(k)) begin errors++; $display("FAIL snapshot_busy_len w=%0d: got %0d want %0d", w_of(k), got_len[k], exp_len(k)); end
      for (int i = 0; i <= nb_of(k); i++) begin
        checks++;
        if (got_sym(k, i) !== exp_sym(k, i)) begin errors++; $display("FAIL snapshot_byte w=%0d i=%0d: got %h want %h", w_of(k), i, got_sym(k, i), exp_sym(k, i)); end
      end
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (busy_of(k) !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL ignored_send_queued: busy samples %0d want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int seen;
    @(negedge clk);
    for (int k = 0; k < 3; k++) exp_res[k] = model_result(k);
    exp_mode = mode_m;
    for (int k = 0; k < 3; k++) set_send(k, 1'b1);
    @(negedge clk);
    fork
      b2b(0);
      b2b(1);
      b2b(2);
    join
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (len1[k] !== exp_len(k)) begin errors++; $display("FAIL b2b_first_len w=%0d: got %0d want %0d", w_of(k), len1[k], exp_len(k)); end
      checks++;
      if (gap[k] !== 1) begin errors++; $display("FAIL b2b_gap w=%0d: got %0d want 1", w_of(k), gap[k]); end
      checks++;
      if (got_len[k] !== exp_len(k)) begin errors++; $display("FAIL b2b_second_len w=%0d: got %0d want %0d", w_of(k), got_len[k], exp_len(k)); end
      for (int i = 0; i <= nb_of(k); i++) begin
        checks++;
        if (got_sym(k, i) !== exp_sym(k, i)) begin errors++; $display("FAIL b2b_byte w=%0d i=%0d: got %h want %h", w_of(k), i, got_sym(k, i), exp_sym(k, i)); end
      end
    end
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (busy_of(k) !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL b2b_third_frame: busy samples %0d want 0", seen); end
  endtask

  task automatic test_reset_mid_frame();
    load(1'b1, 1'b0, 32'h5A, 1'b0);
    load(1'b0, 1'b1, 32'h21, 1'b0);
    send_start();
    repeat (115) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (txd_of(k) !== 1'b1) begin errors++; $display("FAIL abort_txd w=%0d: got %b want 1", w_of(k), txd_of(k)); end
      checks++;
      if (busy_of(k) !== 1'b0) begin errors++; $display("FAIL abort_busy w=%0d: got %b want 0", w_of(k), busy_of(k)); end
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin a_m[k] = 0; b_m[k] = 0; end
    load(1'b1, 1'b0, 32'hC3, 1'b1);
    load(1'b0, 1'b1, 32'h3D, 1'b1);
    send_start();
    capture_all();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_len[k] !== exp_len(k)) begin errors++; $display("FAIL after_abort_len w=%0d: got %0d want %0d", w_of(k), got_len[k], exp_len(k)); end
      for (int i = 0; i <= nb_of(k); i++) begin
        checks++;
        if (got_sym(k, i) !== exp_sym(k, i)) begin errors++; $display("FAIL after_abort_byte w=%0d i=%0d: got %h want %h", w_of(k), i, got_sym(k, i), exp_sym(k, i)); end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d1;
    logic [31:0] d2;
    logic        md;
    for (int it = 0; it < 4; it++) begin
      d1 = $urandom;
      d2 = $urandom;
      md = 1'($urandom_range(0, 1));
      load(1'b1, 1'b0, d1, md);
      load(1'b0, 1'b1, d2, md);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (result_of(k) !== model_result(k)) begin errors++; $display("FAIL rand_result w=%0d it=%0d: got %0h want %0h", w_of(k), it, result_of(k), model_result(k)); end
      end
      send_start();
      capture_all();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_len[k] !== exp_len(k)) begin errors++; $display("FAIL rand_busy_len w=%0d it=%0d: got %0d want %0d", w_of(k), it, got_len[k], exp_len(k)); end
        for (int i = 0; i <= nb_of(k); i++) begin
          checks++;
          if (got_sym(k, i) !== exp_sym(k, i)) begin errors++; $display("FAIL rand_byte w=%0d it=%0d i=%0d: got %h want %h", w_of(k), it, i, got_sym(k, i), exp_sym(k, i)); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub_negative();
    test_simultaneous();
    test_width();
    test_ignored_send();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sum_latch_uart_frame_tx.md
Name: sum_latch_uart_frame_tx

Overview:
Parametrised successor of the 4-bit latch/adder/UART path. Two W-bit operands are captured from a shared input bus. A registered add or subtract result is produced. On request, the result is serialised as a framed multi-byte UART message: a header byte, then the result bytes LSB-first. The block sits between the board switch/button inputs and the UART TX pin, and has its own baud generator and serialiser FSM.

Parameters:
W, 8, operand width in bits (2..32)
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, must be >= 2)
HEADER, 8'hA5, first byte of every frame

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
save_a_n  input  1  active-low; while low at a clk edge, A <= data_input
save_b_n  input  1  active-low; while low at a clk edge, B <= data_input
data_input  input  W  shared operand bus
mode  input  1  0 = add (A+B), 1 = subtract (A-B)
send  input  1  active-high request to transmit the current result
result  output  W+1  registered result of the current A, B, mode
uart_txd  output  1  serial output, idle high
uart_busy  output  1  high while a frame is in progress

Behaviour:
- Reset (async, active-high): A=0, B=0, result=0, uart_txd=1, uart_busy=0, FSM=IDLE, all counters 0. Reset mid-frame aborts the frame immediately; uart_txd returns high asynchronously.
- Capture: save_a_n and save_b_n are independent. Both low in the same cycle loads both registers with the same value. Capture is allowed during transmission.
- Result register: updated every cycle from the current A, B, mode. result reflects a capture 2 clocks after the save edge.
  - Add: zero-extend both operands to W+1 bits and sum. Bit W is the carry.
  - Subtract: W+1-bit two's complement A-B. Bit W is the borrow/sign.
- Frame: NB = ceil((W+1)/8) result bytes. Total bytes = 1 + NB.
  - The result is padded to 8*NB bits. Padding is zero for an add. For a subtract, padding copies result[W] (sign extension), using the mode snapshotted at acceptance.
- Send acceptance: send=1 while uart_busy=0 and FSM=IDLE.
  - The next edge snapshots the padded result and mode into a shift buffer, sets uart_busy=1 and enters START.
  - send while busy is ignored; it is not queued.
  - A send held high continuously starts a new frame on the first IDLE cycle after the previous frame ends.
- FSM states: IDLE, START, DATA, STOP.
  - START: txd=0 for CLKS_PER_BIT clocks -> DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT clocks -> STOP.
  - STOP: txd=1 for CLKS_PER_BIT clocks. If more bytes remain, load the next byte -> START (no idle gap). Otherwise -> IDLE and clear uart_busy on the same edge.
- Byte order: HEADER, then result byte 0 (bits 7:0), byte 1, and so on.
- Frame length: exactly (1+NB)*10*CLKS_PER_BIT clocks from the first START clock to busy falling.
- Operand changes during a frame do not alter the bytes in flight; the snapshot is used.
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps, and restarts at 0 on every state entry.
- Bit and byte counters: bit counter wraps 7->0; byte counter reaches NB, then the frame ends.

Test Plan:
- Reset mid-frame: assert reset during the DATA state of byte 1 -> uart_txd=1 and uart_busy=0 immediately; after release, send produces a complete fresh frame.
- Add with carry (W=8, CLK_HZ=1000, BAUD=100 -> 10 clk/bit): load A=200, B=100, mode=0 -> result=9'h12C. send -> bytes A5, 2C, 01 decoded on uart_txd. uart_busy is high for exactly 300 clocks.
- Subtract negative (W=8): A=5, B=7, mode=1 -> result=9'h1FE. Frame bytes A5, FE, FF (sign-extended).
- Ignored send / snapshot: mid-frame, pulse send and change B via save_b_n -> the frame is unchanged and no second frame follows. result updates to the new value within 2 clocks.
- Simultaneous save: save_a_n=save_b_n=0 with data_input=8'hFF, mode=0 -> A=B=FF, result=9'h1FE. Frame A5, FE, 01.
- Width generalisation (W=15, NB=2): A=16'h7FFF, B=1, add -> result=16'h8000. Frame A5, 00, 80. W=16 (NB=3): A=B=16'hFFFF -> 17'h1FFFE. Frame A5, FE, FF, 01.
